// File: rtl/datapath.sv
// ============================================================================
// Module   : datapath
// Purpose  : 32-bit CPU datapath with register file, single shared bus,
//            64-bit Z register and a 13-operation ALU.
// Revision : 1.0
// ============================================================================
`default_nettype none

module datapath_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [31:0] i_d,
    output logic [31:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (i_en)
            q <= i_d;
    end
endmodule

module datapath (
    input  logic        clock,
    input  logic        clear,
    input  logic        R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
    input  logic        R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        Zhighin,
    input  logic        Zlowin,
    input  logic        PCin,
    input  logic        MDRin,
    input  logic        In_Portin,
    input  logic        Coutin,
    input  logic        Read,
    input  logic        IRin,
    input  logic        MARin,
    input  logic        Yin,
    input  logic        Zin,
    input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        Zhighout,
    input  logic        Zlowout,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        In_Portout,
    input  logic        Coutout,
    input  logic        IncPC,
    input  logic [31:0] Mdatain,
    input  logic [4:0]  ALU_Control,
    output logic [31:0] Out_Portout
);
    localparam logic [4:0] c_ADD  = 5'b00000;
    localparam logic [4:0] c_SUB  = 5'b00001;
    localparam logic [4:0] c_AND  = 5'b00010;
    localparam logic [4:0] c_OR   = 5'b00011;
    localparam logic [4:0] c_SHR  = 5'b00100;
    localparam logic [4:0] c_SHRA = 5'b00101;
    localparam logic [4:0] c_SHL  = 5'b00110;
    localparam logic [4:0] c_ROR  = 5'b00111;
    localparam logic [4:0] c_ROL  = 5'b01000;
    localparam logic [4:0] c_MUL  = 5'b01001;
    localparam logic [4:0] c_DIV  = 5'b01010;
    localparam logic [4:0] c_NEG  = 5'b01011;
    localparam logic [4:0] c_NOT  = 5'b01100;

    logic [15:0] w_rin;
    logic [31:0] w_gpr [0:15];
    logic [31:0] w_bus;
    logic [31:0] w_hi, w_lo, w_pc, w_ir, w_mar, w_mdr, w_y, w_c;
    logic [31:0] w_mdr_d;
    logic [63:0] r_z;
    logic [63:0] w_alu;
    logic [23:0] w_sel;
    logic [31:0] w_src [0:23];
    logic        w_unused_obs;

    assign w_rin = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

    datapath_reg R0  (.clk(clock), .rst(clear), .i_en(w_rin[0]),  .i_d(w_bus), .q(w_gpr[0]));
    datapath_reg R1  (.clk(clock), .rst(clear), .i_en(w_rin[1]),  .i_d(w_bus), .q(w_gpr[1]));
    datapath_reg R2  (.clk(clock), .rst(clear), .i_en(w_rin[2]),  .i_d(w_bus), .q(w_gpr[2]));
    datapath_reg R3  (.clk(clock), .rst(clear), .i_en(w_rin[3]),  .i_d(w_bus), .q(w_gpr[3]));
    datapath_reg R4  (.clk(clock), .rst(clear), .i_en(w_rin[4]),  .i_d(w_bus), .q(w_gpr[4]));
    datapath_reg R5  (.clk(clock), .rst(clear), .i_en(w_rin[5]),  .i_d(w_bus), .q(w_gpr[5]));
    datapath_reg R6  (.clk(clock), .rst(clear), .i_en(w_rin[6]),  .i_d(w_bus), .q(w_gpr[6]));
    datapath_reg R7  (.clk(clock), .rst(clear), .i_en(w_rin[7]),  .i_d(w_bus), .q(w_gpr[7]));
    datapath_reg R8  (.clk(clock), .rst(clear), .i_en(w_rin[8]),  .i_d(w_bus), .q(w_gpr[8]));
    datapath_reg R9  (.clk(clock), .rst(clear), .i_en(w_rin[9]),  .i_d(w_bus), .q(w_gpr[9]));
    datapath_reg R10 (.clk(clock), .rst(clear), .i_en(w_rin[10]), .i_d(w_bus), .q(w_gpr[10]));
    datapath_reg R11 (.clk(clock), .rst(clear), .i_en(w_rin[11]), .i_d(w_bus), .q(w_gpr[11]));
    datapath_reg R12 (.clk(clock), .rst(clear), .i_en(w_rin[12]), .i_d(w_bus), .q(w_gpr[12]));
    datapath_reg R13 (.clk(clock), .rst(clear), .i_en(w_rin[13]), .i_d(w_bus), .q(w_gpr[13]));
    datapath_reg R14 (.clk(clock), .rst(clear), .i_en(w_rin[14]), .i_d(w_bus), .q(w_gpr[14]));
    datapath_reg R15 (.clk(clock), .rst(clear), .i_en(w_rin[15]), .i_d(w_bus), .q(w_gpr[15]));

    assign w_mdr_d = Read ? Mdatain : w_bus;

    datapath_reg u_hi      (.clk(clock), .rst(clear), .i_en(HIin),      .i_d(w_bus),   .q(w_hi));
    datapath_reg u_lo      (.clk(clock), .rst(clear), .i_en(LOin),      .i_d(w_bus),   .q(w_lo));
    datapath_reg u_pc      (.clk(clock), .rst(clear), .i_en(PCin),      .i_d(w_bus),   .q(w_pc));
    datapath_reg u_ir      (.clk(clock), .rst(clear), .i_en(IRin),      .i_d(w_bus),   .q(w_ir));
    datapath_reg u_mar     (.clk(clock), .rst(clear), .i_en(MARin),     .i_d(w_bus),   .q(w_mar));
    datapath_reg u_mdr     (.clk(clock), .rst(clear), .i_en(MDRin),     .i_d(w_mdr_d), .q(w_mdr));
    datapath_reg u_y       (.clk(clock), .rst(clear), .i_en(Yin),       .i_d(w_bus),   .q(w_y));
    datapath_reg u_c       (.clk(clock), .rst(clear), .i_en(Coutin),    .i_d(w_bus),   .q(w_c));
    datapath_reg u_in_port (.clk(clock), .rst(clear), .i_en(In_Portin), .i_d(w_bus),   .q(Out_Portout));

    // IR and MAR are consumed by control/memory logic outside this block.
    assign w_unused_obs = ^{w_ir, w_mar};

    // Bus sources in priority order; index 0 wins.
    assign w_sel = {Coutout, In_Portout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                    R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    always_comb begin
        for (int i = 0; i < 16; i++)
            w_src[i] = w_gpr[i];
        w_src[16] = w_hi;
        w_src[17] = w_lo;
        w_src[18] = r_z[63:32];
        w_src[19] = r_z[31:0];
        w_src[20] = w_pc;
        w_src[21] = w_mdr;
        w_src[22] = Out_Portout;
        w_src[23] = w_c;
    end

    always_comb begin
        w_bus = '0;
        for (int i = 23; i >= 0; i--)
            if (w_sel[i])
                w_bus = w_src[i];
    end

    logic [4:0]         w_sh;
    logic [4:0]         w_rol_sh;
    logic [31:0]        w_ror, w_rol;
    logic signed [63:0] w_a64, w_b64, w_b_safe, w_prod, w_quo, w_rem;

    assign w_sh     = w_bus[4:0];
    assign w_rol_sh = 5'd0 - w_sh;
    assign w_ror    = 32'({w_y, w_y} >> w_sh);
    assign w_rol    = 32'({w_y, w_y} >> w_rol_sh);
    assign w_a64    = $signed({{32{w_y[31]}}, w_y});
    assign w_b64    = $signed({{32{w_bus[31]}}, w_bus});
    assign w_prod   = w_a64 * w_b64;
    // 64-bit signed division keeps the -2^31 / -1 case representable.
    assign w_b_safe = (w_bus == 32'd0) ? 64'sd1 : w_b64;
    assign w_quo    = w_a64 / w_b_safe;
    assign w_rem    = w_a64 % w_b_safe;

    always_comb begin
        w_alu = '0;
        if (IncPC) begin
            w_alu[31:0] = w_bus + 32'd1;
        end else begin
            case (ALU_Control)
                c_ADD:   w_alu[31:0] = w_y + w_bus;
                c_SUB:   w_alu[31:0] = w_y - w_bus;
                c_AND:   w_alu[31:0] = w_y & w_bus;
                c_OR:    w_alu[31:0] = w_y | w_bus;
                c_SHR:   w_alu[31:0] = w_y >> w_sh;
                c_SHRA:  w_alu[31:0] = $unsigned($signed(w_y) >>> w_sh);
                c_SHL:   w_alu[31:0] = w_y << w_sh;
                c_ROR:   w_alu[31:0] = w_ror;
                c_ROL:   w_alu[31:0] = w_rol;
                c_MUL:   w_alu       = $unsigned(w_prod);
                c_DIV:   if (w_bus != 32'd0)
                             w_alu = {32'(w_rem), 32'(w_quo)};
                c_NEG:   w_alu[31:0] = 32'd0 - w_bus;
                c_NOT:   w_alu[31:0] = ~w_bus;
                default: w_alu = '0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_z <= '0;
        end else if (Zin) begin
            r_z <= w_alu;
        end else begin
            if (Zhighin)
                r_z[63:32] <= w_bus;
            if (Zlowin)
                r_z[31:0] <= w_bus;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_datapath.sv
// ============================================================================
// Module   : tb_datapath
// Purpose  : Self-checking bench for datapath against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_datapath;
    logic        clock = 1'b0;
    logic        clear;
    logic [15:0] rin, rout;
    logic HIin, LOin, Zhighin, Zlowin, PCin, MDRin, In_Portin, Coutin, Read;
    logic IRin, MARin, Yin, Zin;
    logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout, In_Portout, Coutout, IncPC;
    logic [31:0] Mdatain;
    logic [4:0]  ALU_Control;
    logic [31:0] Out_Portout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    datapath dut (
        .clock(clock), .clear(clear),
        .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
        .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
        .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin), .PCin(PCin),
        .MDRin(MDRin), .In_Portin(In_Portin), .Coutin(Coutin), .Read(Read),
        .IRin(IRin), .MARin(MARin), .Yin(Yin), .Zin(Zin),
        .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
        .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
        .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCout(PCout), .MDRout(MDRout), .In_Portout(In_Portout), .Coutout(Coutout),
        .IncPC(IncPC), .Mdatain(Mdatain), .ALU_Control(ALU_Control),
        .Out_Portout(Out_Portout)
    );

    task automatic idle();
        rin = '0; rout = '0;
        HIin = 0; LOin = 0; Zhighin = 0; Zlowin = 0; PCin = 0; MDRin = 0;
        In_Portin = 0; Coutin = 0; Read = 0; IRin = 0; MARin = 0; Yin = 0; Zin = 0;
        HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; MDRout = 0;
        In_Portout = 0; Coutout = 0; IncPC = 0; Mdatain = '0; ALU_Control = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1; step(); idle();
    endtask

    task automatic load_gpr(input int idx, input logic [31:0] v);
        load_mdr(v); MDRout = 1; rin[idx] = 1; step(); idle();
    endtask

    task automatic load_y(input logic [31:0] v);
        load_mdr(v); MDRout = 1; Yin = 1; step(); idle();
    endtask

    // Y = a, bus = b (driven from MDR), capture into Z.
    task automatic alu_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] op, input logic inc);
        load_y(a); load_mdr(b);
        MDRout = 1; ALU_Control = op; IncPC = inc; Zin = 1; step(); idle();
    endtask

    function automatic logic [63:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [4:0] op, input logic inc);
        int     s;
        logic [31:0] r;
        logic signed [31:0] sa;
        longint pa, pb, q, m;
        if (inc) return {32'b0, b + 32'd1};
        s  = int'(b % 32);
        sa = a;
        pa = longint'(sa);
        pb = longint'($signed(b));
        r  = a;
        case (op)
            5'd0:  return {32'b0, a + b};
            5'd1:  return {32'b0, a - b};
            5'd2:  return {32'b0, a & b};
            5'd3:  return {32'b0, a | b};
            5'd4:  return {32'b0, a >> s};
            5'd5:  begin sa = sa >>> s; return {32'b0, sa}; end
            5'd6:  return {32'b0, a << s};
            5'd7:  begin repeat (s) r = {r[0], r[31:1]}; return {32'b0, r}; end
            5'd8:  begin repeat (s) r = {r[30:0], r[31]}; return {32'b0, r}; end
            5'd9:  return pa * pb;
            5'd10: begin
                if (b == 0) return 64'd0;
                q = pa / pb; m = pa % pb;
                return {m[31:0], q[31:0]};
            end
            5'd11: return {32'b0, 32'd0 - b};
            5'd12: return {32'b0, ~b};
            default: return 64'd0;
        endcase
    endfunction

    task automatic test_reset();
        idle();
        clear = 1;
        Mdatain = 32'hFFFF_FFFF; Read = 1; MDRin = 1; rin = '1; Zin = 1; IncPC = 1; In_Portin = 1;
        step();
        n_tests++; if (Out_Portout !== 32'd0) begin n_fail++; $display("FAIL reset_outport got=%h exp=0", Out_Portout); end
        n_tests++; if (dut.R2.q !== 32'd0) begin n_fail++; $display("FAIL reset_r2 got=%h exp=0", dut.R2.q); end
        n_tests++; if (dut.u_mdr.q !== 32'd0) begin n_fail++; $display("FAIL reset_mdr_override got=%h exp=0", dut.u_mdr.q); end
        n_tests++; if (dut.r_z !== 64'd0) begin n_fail++; $display("FAIL reset_z got=%h exp=0", dut.r_z); end
        idle();
        clear = 0;
        step();
    endtask

    task automatic test_add_sequence();
        load_gpr(5, 32'h34);
        load_gpr(6, 32'h45);
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1; step(); idle();
        Zlowout = 1; PCin = 1; Read = 1; MDRin = 1; Mdatain = 32'h112B_0000; step(); idle();
        MDRout = 1; IRin = 1; step(); idle();
        rout[5] = 1; Yin = 1; step(); idle();
        rout[6] = 1; ALU_Control = 5'b00000; Zin = 1; step(); idle();
        Zlowout = 1; rin[2] = 1; step(); idle();
        n_tests++; if (dut.R5.q !== 32'h34) begin n_fail++; $display("FAIL add_r5 got=%h exp=34", dut.R5.q); end
        n_tests++; if (dut.R6.q !== 32'h45) begin n_fail++; $display("FAIL add_r6 got=%h exp=45", dut.R6.q); end
        n_tests++; if (dut.u_ir.q !== 32'h112B_0000) begin n_fail++; $display("FAIL add_ir got=%h exp=112b0000", dut.u_ir.q); end
        n_tests++; if (dut.u_pc.q !== 32'd1) begin n_fail++; $display("FAIL add_pc got=%h exp=1", dut.u_pc.q); end
        n_tests++; if (dut.R2.q !== 32'h79) begin n_fail++; $display("FAIL add_r2 got=%h exp=79", dut.R2.q); end
    endtask

    task automatic test_directed_alu();
        alu_op(32'h10, 32'h20, 5'b00001, 0);
        n_tests++; if (dut.r_z[31:0] !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL sub_zlow got=%h exp=fffffff0", dut.r_z[31:0]); end
        alu_op(32'hFFFF_FFFE, 32'd3, 5'b01001, 0);
        Zhighout = 1; HIin = 1; step(); idle();
        Zlowout = 1; LOin = 1; step(); idle();
        n_tests++; if (dut.u_hi.q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mul_hi got=%h exp=ffffffff", dut.u_hi.q); end
        n_tests++; if (dut.u_lo.q !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mul_lo got=%h exp=fffffffa", dut.u_lo.q); end
        alu_op(32'd7, 32'd2, 5'b01010, 0);
        n_tests++; if (dut.r_z !== {32'd1, 32'd3}) begin n_fail++; $display("FAIL div_7_2 got=%h exp=0000000100000003", dut.r_z); end
        alu_op(32'd7, 32'd0, 5'b01010, 0);
        n_tests++; if (dut.r_z !== 64'd0) begin n_fail++; $display("FAIL div_by_zero got=%h exp=0", dut.r_z); end
        // Zin must win over the half loads.
        alu_op(32'd1, 32'd2, 5'b00000, 0);
        load_mdr(32'hDEAD_BEEF);
        MDRout = 1; Zin = 1; Zhighin = 1; Zlowin = 1; ALU_Control = 5'b01100; step(); idle();
        n_tests++; if (dut.r_z !== {32'd0, 32'h2152_4110}) begin n_fail++; $display("FAIL zin_priority got=%h exp=0000000021524110", dut.r_z); end
        MDRout = 1; Zhighin = 1; step(); idle();
        n_tests++; if (dut.r_z !== {32'hDEAD_BEEF, 32'h2152_4110}) begin n_fail++; $display("FAIL zhighin got=%h exp=deadbeef21524110", dut.r_z); end
    endtask

    task automatic test_bus_priority();
        logic [31:0] vals [0:15];
        logic [31:0] hi_val, exp;
        logic [15:0] mask;
        logic        hi_sel;
        load_gpr(1, 32'h1111_1111);
        load_gpr(3, 32'h3333_3333);
        rout[1] = 1; rout[3] = 1; rin[4] = 1; step(); idle();
        n_tests++; if (dut.R4.q !== 32'h1111_1111) begin n_fail++; $display("FAIL prio_r1_r3 got=%h exp=11111111", dut.R4.q); end
        rin[4] = 1; step(); idle();
        n_tests++; if (dut.R4.q !== 32'd0) begin n_fail++; $display("FAIL prio_none got=%h exp=0", dut.R4.q); end
        for (int i = 0; i < 16; i++) begin
            vals[i] = $urandom();
            load_gpr(i, vals[i]);
        end
        hi_val = $urandom();
        load_mdr(hi_val); MDRout = 1; HIin = 1; step(); idle();
        for (int k = 0; k < 24; k++) begin
            mask   = (k % 6 == 0) ? 16'd0 : 16'($urandom());
            hi_sel = 1'($urandom_range(0, 1));
            exp    = hi_sel ? hi_val : 32'd0;
            for (int i = 15; i >= 0; i--)
                if (mask[i]) exp = vals[i];
            rout = mask; HIout = hi_sel; In_Portin = 1; step(); idle();
            n_tests++;
            if (Out_Portout !== exp) begin
                n_fail++;
                $display("FAIL prio_random mask=%h hi=%0d got=%h exp=%h", mask, hi_sel, Out_Portout, exp);
            end
        end
    endtask

    task automatic test_alu_random();
        logic [31:0] a, b;
        logic [4:0]  op;
        logic        inc;
        logic [63:0] exp;
        for (int k = 0; k < 60; k++) begin
            a   = $urandom();
            b   = (k % 4 == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom());
            if (k % 13 == 0) b = 32'd0;
            op  = 5'($urandom_range(0, 16));
            inc = ($urandom_range(0, 9) == 0);
            exp = alu_model(a, b, op, inc);
            alu_op(a, b, op, inc);
            n_tests++;
            if (dut.r_z !== exp) begin
                n_fail++;
                $display("FAIL alu_random op=%0d inc=%0d a=%h b=%h got=%h exp=%h", op, inc, a, b, dut.r_z, exp);
            end
            Zlowout = 1; In_Portin = 1; step(); idle();
            n_tests++;
            if (Out_Portout !== exp[31:0]) begin
                n_fail++;
                $display("FAIL alu_zlow_bus op=%0d got=%h exp=%h", op, Out_Portout, exp[31:0]);
            end
            Zhighout = 1; Coutin = 1; step(); idle();
            Coutout = 1; In_Portin = 1; step(); idle();
            n_tests++;
            if (Out_Portout !== exp[63:32]) begin
                n_fail++;
                $display("FAIL alu_zhigh_via_c op=%0d got=%h exp=%h", op, Out_Portout, exp[63:32]);
            end
        end
    endtask

    task automatic test_clear_mid();
        load_gpr(2, 32'h79);
        PCout = 1; IncPC = 1; Zin = 1; step(); idle();
        Zlowout = 1; PCin = 1; In_Portin = 1; step(); idle();
        @(negedge clock);
        clear = 1;
        #1;
        n_tests++; if (dut.R2.q !== 32'd0) begin n_fail++; $display("FAIL clear_mid_r2 got=%h exp=0", dut.R2.q); end
        n_tests++; if (dut.u_pc.q !== 32'd0) begin n_fail++; $display("FAIL clear_mid_pc got=%h exp=0", dut.u_pc.q); end
        n_tests++; if (dut.r_z !== 64'd0) begin n_fail++; $display("FAIL clear_mid_z got=%h exp=0", dut.r_z); end
        n_tests++; if (Out_Portout !== 32'd0) begin n_fail++; $display("FAIL clear_mid_outport got=%h exp=0", Out_Portout); end
        clear = 0;
        load_gpr(2, 32'h5A5A_0001);
        n_tests++; if (dut.R2.q !== 32'h5A5A_0001) begin n_fail++; $display("FAIL clear_resume got=%h exp=5a5a0001", dut.R2.q); end
    endtask

    initial begin
        clear = 1;
        idle();
        test_reset();
        test_add_sequence();
        test_directed_alu();
        test_bus_priority();
        test_alu_random();
        test_clear_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 The module SHALL have one clock, `clock`: 1-bit input; all register updates occur on its rising edge.
REQ-002 `clear` SHALL be a 1-bit input reset, asynchronous and active-high.
REQ-003 `R0in`..`R15in` SHALL be sixteen 1-bit inputs; `Rnin` loads register Rn from the bus.
REQ-004 `HIin`, `LOin`, `Zhighin`, `Zlowin`, `PCin`, `MDRin`, `In_Portin`, `Coutin`, `IRin`, `MARin`, `Yin` SHALL be 1-bit inputs; each loads the named register.
REQ-005 `Read` (1-bit in) SHALL select the MDR source; `Zin` (1-bit in) SHALL capture the ALU result into Z.
REQ-006 `R0out`..`R15out`, `HIout`, `LOout`, `Zhighout`, `Zlowout`, `PCout`, `MDRout`, `In_Portout`, `Coutout` SHALL be 1-bit inputs; each drives the named register onto the bus.
REQ-007 `IncPC` (1-bit in) SHALL force the ALU to compute bus+1.
REQ-008 `Mdatain` (32-bit in) SHALL be the memory read data.
REQ-009 `ALU_Control` (5-bit in) SHALL be the ALU opcode.
REQ-010 `Out_Portout` (32-bit out) SHALL be the current In_Port register value.
REQ-011 Port order SHALL be: `clock`, `clear`, R0in-R15in, `HIin`, `LOin`, `Zhighin`, `Zlowin`, `PCin`, `MDRin`, `In_Portin`, `Coutin`, `Read`, `IRin`, `MARin`, `Yin`, `Zin`, R0out-R15out, `HIout`, `LOout`, `Zhighout`, `Zlowout`, `PCout`, `MDRout`, `In_Portout`, `Coutout`, `IncPC`, `Mdatain`, `ALU_Control`, `Out_Portout`.

Function
REQ-012 The block SHALL contain 32-bit registers R0-R15, HI, LO, PC, IR, MAR, MDR, Y, In_Port and C, plus a 64-bit Z (Zhigh = [63:32], Zlow = [31:0]).
REQ-013 R0-R15 SHALL be separate register instances named `R0`..`R15`, each exposing its stored value on output `q`.
REQ-014 Each register SHALL load on the rising clock edge while its in-enable is 1 and hold its value otherwise; R0 is an ordinary register.
REQ-015 The 32-bit bus SHALL be combinational, driven by the asserted out-select.
  - Fixed priority when several are asserted: R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, In_Portout, Coutout (first wins).
  - When none is asserted, the bus SHALL be 0.
REQ-016 MDR SHALL load `Mdatain` when `MDRin`=1 and `Read`=1, and load the bus when `MDRin`=1 and `Read`=0.
REQ-017 ALU operands SHALL be A = Y and B = bus; the result SHALL be 64-bit and combinational.
REQ-018 ALU_Control encoding (result in Zlow, Zhigh=0 unless noted):
  - 00000 ADD A+B
  - 00001 SUB A-B
  - 00010 AND
  - 00011 OR
  - 00100 SHR A>>B[4:0] logical
  - 00101 SHRA arithmetic
  - 00110 SHL
  - 00111 ROR
  - 01000 ROL
  - 01001 MUL: signed 64-bit product in Z
  - 01010 DIV: signed; Zlow = quotient, Zhigh = remainder; B=0 gives Z=0
  - 01011 NEG -B
  - 01100 NOT ~B
  - other codes: Z result 0
REQ-019 ADD and SUB SHALL be modulo 2^32 with no overflow flag.
REQ-020 When `IncPC`=1 the ALU result SHALL be {32'b0, B+1} regardless of `ALU_Control`.
REQ-021 `Zin`=1 SHALL load the full 64-bit ALU result into Z.
REQ-022 When `Zin`=0, `Zhighin`/`Zlowin` SHALL load the bus into the respective Z half; `Zin` SHALL take priority over them.
REQ-023 All transfers SHALL complete in one clock: the bus value is sampled by destination registers at the same edge.

Reset
REQ-024 `clear`=1 SHALL immediately set every register, including both Z halves, to 0, independent of `clock`; `Out_Portout` SHALL read 0.
REQ-025 `clear` SHALL override all load enables.
REQ-026 After `clear` deasserts, operation SHALL resume at the next rising edge; reset mid-sequence loses all state.

Verification
REQ-027 ADD sequence -> `R5.q`=0x34, `R6.q`=0x45, IR=0x112B0000, PC=1, `R2.q`=0x00000079:
  - Mdatain=0x34 with Read+MDRin, then MDRout+R5in.
  - 0x45 likewise into R6.
  - PCout+MARin+IncPC+Zin, then Zlowout+PCin+Read+MDRin with Mdatain=0x112B0000, then MDRout+IRin.
  - R5out+Yin; R6out+ALU_Control=00000+Zin; Zlowout+R2in.
REQ-028 SUB: Y=0x10, bus=0x20, op 00001 -> Zlow=0xFFFFFFF0.
REQ-029 MUL: Y=0xFFFFFFFE (-2), bus=3, op 01001, then Zhighout+HIin and Zlowout+LOin -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 DIV: Y=7, bus=2 -> Zlow=3, Zhigh=1; bus=0 -> Z=0.
REQ-031 Bus priority: R1out and R3out asserted together with R4in -> R4 = R1; no out asserted with R4in -> R4=0.
REQ-032 Reset: `clear` pulsed between clock edges after loading R2=0x79 -> R2, PC and Z read 0 before the next edge.
